uart_rx_scan: RTL and testbench
===============================

Name: uart_rx_scan

Overview:
Scan-inserted UART receiver; the downstream consumer of the scan-inserted UART transmitter's tx_out, wired directly or through a loopback path. It deserialises 8N1 frames (start bit, 8 data bits LSB-first, stop bit) and presents each byte with a one-cycle valid pulse. Every flop sits on a single mux-D scan chain so ATPG covers the receive path.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per UART bit. Must be ≥1. Default 1 matches the transmitter's one-bit-per-clock timing.
- CW, derived as max(1, ceil(log2(CLKS_PER_BIT))), baud counter width. Not user-set.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_in  input  1  serial line; idle high.
- scan_enable  input  1  1 = all flops shift scan_in→scan_out.
- scan_in  input  1  scan chain input.
- scan_out  output  1  scan chain output; Q of the last chain flop.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered except rx_busy, which decodes the state.
- Reset, applied when reset=0 and scan_enable=0:
  - state=IDLE; baud counter, bit index and shift register cleared.
  - rx_data=0x00, rx_valid=0, rx_frame_err=0.
- scan_enable=1 has priority over reset and all functional updates. It only shifts the chain.
- Scan chain order, scan_in first: state[2:0], baud_cnt[CW-1:0], bit_idx[2:0], shift[7:0], rx_data[7:0], rx_valid, rx_frame_err, then synchroniser flops if present. Length is 24+CW, which is 25 at default.
- State encoding is 3-bit binary: IDLE=000, START=001, DATA=010, STOP=011, WAIT_HIGH=100. All unused codes go to IDLE on the next functional clock.
- HALF=(CLKS_PER_BIT-1)/2, using integer division.
- IDLE: a clock edge sampling rx_in=0 is the falling-edge detection.
  - If HALF=0, that sample is the start-bit check: go to DATA, with bit_idx=0.
  - Otherwise go to START and clear baud_cnt.
- START: sample HALF cycles after detection.
  - Sample 0 → DATA.
  - Sample 1 → IDLE, treated as a glitch. No output pulse.
- DATA: sample every CLKS_PER_BIT cycles after the previous sample.
  - Each sample does shift={sample, shift[7:1]} and bit_idx+1.
  - After the 8th sample (bit_idx wraps 7→0) → STOP.
- STOP: sample CLKS_PER_BIT cycles after the 8th data sample.
  - Sample 1: next cycle rx_data=shift and rx_valid=1 for exactly one cycle. → IDLE.
  - Sample 0: next cycle rx_frame_err=1 for one cycle; rx_data unchanged. → WAIT_HIGH.
- WAIT_HIGH: remain until rx_in samples 1, then → IDLE. This prevents a held-low break from being read as repeated frames.
- Latency at CLKS_PER_BIT=1, with start bit on the line during cycle T:
  - Data bits are sampled at cycles T+1..T+8.
  - The stop bit is sampled at T+9.
  - rx_valid is high during T+10, aligned with the transmitter's tx_done.
- Back-to-back frames: a new start bit is accepted in the cycle immediately after the STOP sample. The IDLE→detect path has no dead cycle.
- Reset mid-frame: abort immediately to IDLE. No rx_valid or rx_frame_err pulse. rx_data is cleared to 0x00.
- rx_valid and rx_frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - rx_in passes through a 2-flop synchroniser (reset value 1) before all logic.
  - The two flops are appended to the end of the scan chain, making it 26+CW long.
  - All receive latencies grow by exactly 2 cycles. At default, rx_valid is high in T+12.
- Undefined:
  - rx_in feeds the FSM directly, with latencies as stated above.
  - Chain length is 24+CW.

Test Plan:
1. Loopback from the UART transmitter, CLKS_PER_BIT=1, tx_data=0xA5 → rx_valid pulses once with rx_data=0xA5, in the same cycle tx_done=1; rx_frame_err stays 0.
2. Drive start, bits of 0x3C, then stop=0 → rx_frame_err pulses once; rx_data keeps its previous value. Hold rx_in=0 for 20 cycles → no further pulses. Release high, then send 0x81 → rx_valid with 0x81.
3. CLKS_PER_BIT=16: 3-cycle low glitch, then line high → returns to IDLE, no pulses. Then a full frame of 0x5A → rx_data=0x5A.
4. Back-to-back frames 0x00 then 0xFF with zero idle gap → two rx_valid pulses exactly 10 cycles apart, data 0x00 then 0xFF.
5. reset=0 asserted during data bit 4 of a frame → next cycle state IDLE, rx_busy=0, rx_data=0x00, and no pulse for the aborted frame.
6. scan_enable=1, shift pattern 1011… for 25 cycles (27 with UART_RX_SYNC_EN) → scan_out reproduces the pattern delayed by chain length. Loading state=010 with bit_idx=7 and pulsing one functional clock with rx_in=1 → state=011.

Source files
------------

// File: rtl/uart_rx_scan.sv
// uart_rx_scan: 8N1 UART receiver (start, 8 data bits LSB-first, stop) with
// every flop on a single mux-D scan chain.
// Chain order from scan_in: state, baud_cnt, bit_idx, shift, rx_data,
// rx_valid, rx_frame_err, then the synchroniser flops when present.
// Optional feature macro: UART_RX_SYNC_EN adds a 2-flop rx_in synchroniser
// (reset value 1) at the tail of the chain and 2 cycles of receive latency.
module uart_rx_scan #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       scan_enable,
  input  logic       scan_in,
  output logic       scan_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int CW       = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam int CORE_LEN = 24 + CW;

  // Counter values on the cycle a sample is taken.
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_DATA  = 3'b010;
  localparam logic [2:0] ST_STOP  = 3'b011;
  localparam logic [2:0] ST_WAIT  = 3'b100;

  logic [2:0]    state_r, state_s;
  logic [CW-1:0] baud_r, baud_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    data_r, data_s;
  logic          valid_r, valid_s;
  logic          ferr_r, ferr_s;

  logic                rx_s;          // line value seen by the FSM
  logic                start_tick_s;  // mid-start-bit sample point
  logic                bit_tick_s;    // data/stop sample point
  logic [CORE_LEN-1:0] core_s;        // core flops in chain order, MSB nearest scan_in

  assign core_s = {state_r, baud_r, bit_idx_r, shift_r, data_r, valid_r, ferr_r};

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_r;  // [1] first stage, [0] second stage

  // Synchroniser flops: scan takes priority, reset to idle-high, else double-flop rx_in.
  always_ff @(posedge clk) begin
    if (scan_enable) begin
      sync_r <= {core_s[0], sync_r[1]};
    end else if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {rx_in, sync_r[1]};
    end
  end

  assign rx_s     = sync_r[0];
  assign scan_out = sync_r[0];
`else
  assign rx_s     = rx_in;
  assign scan_out = core_s[0];
`endif

  assign start_tick_s = (baud_r == HALF_LAST);
  assign bit_tick_s   = (baud_r == BIT_LAST);

  // State and datapath registers: scan shift, then synchronous reset, then functional update.
  always_ff @(posedge clk) begin
    if (scan_enable) begin
      {state_r, baud_r, bit_idx_r, shift_r, data_r, valid_r, ferr_r} <=
        {scan_in, core_s[CORE_LEN-1:1]};
    end else if (!reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
      ferr_r    <= ferr_s;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_s = (HALF == 0) ? ST_DATA : ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (start_tick_s) begin
          state_s = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s && (bit_idx_r == 3'd7)) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          state_s = rx_s ? ST_IDLE : ST_WAIT;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_WAIT: begin
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath next values: baud counting, bit shifting and the one-cycle result pulses.
  always_comb begin
    baud_s    = {CW{1'b0}};
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    data_s    = data_r;
    valid_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bit_idx_s = 3'd0;
      end
      ST_START: begin
        bit_idx_s = 3'd0;
        if (start_tick_s) begin
          baud_s = {CW{1'b0}};
        end else begin
          baud_s = baud_r + CW'(1'b1);
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          shift_s   = {rx_s, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          baud_s    = {CW{1'b0}};
        end else begin
          baud_s = baud_r + CW'(1'b1);
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          if (rx_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          baud_s = baud_r + CW'(1'b1);
        end
      end
      ST_WAIT: begin
        baud_s = {CW{1'b0}};
      end
      default: begin
        baud_s = {CW{1'b0}};
      end
    endcase
  end

  assign rx_data      = data_r;
  assign rx_valid     = valid_r;
  assign rx_frame_err = ferr_r;
  assign rx_busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_scan.sv
// tb_uart_rx_scan: directed/randomised bench for uart_rx_scan. Two instances:
// dut_a at one clock per bit, dut_b at 16 clocks per bit. Expected receive
// events come from the frame timing rules (detect, half-bit, 9 bit periods).
module tb_uart_rx_scan;
  localparam int CPB_A = 1;
  localparam int CPB_B = 16;
`ifdef UART_RX_SYNC_EN
  localparam int LAT      = 2;
  localparam int SYNC_LEN = 2;
`else
  localparam int LAT      = 0;
  localparam int SYNC_LEN = 0;
`endif
  localparam int CW_A  = 1;
  localparam int LEN_A = 24 + CW_A + SYNC_LEN;

  logic       clk = 1'b0;
  logic       reset, scan_enable;
  logic       rx_a, scan_in_a, scan_out_a, valid_a, err_a, busy_a;
  logic       rx_b, scan_in_b, scan_out_b, valid_b, err_b, busy_b;
  logic [7:0] data_a, data_b;

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int overlap_cnt = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  ev_t ev_m;

  uart_rx_scan #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .reset(reset), .rx_in(rx_a), .scan_enable(scan_enable),
    .scan_in(scan_in_a), .scan_out(scan_out_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_frame_err(err_a), .rx_busy(busy_a)
  );

  uart_rx_scan #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .reset(reset), .rx_in(rx_b), .scan_enable(scan_enable),
    .scan_in(scan_in_b), .scan_out(scan_out_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_frame_err(err_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  // Cycle counter, one step per rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse of both receivers, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_a) begin ev_m.cyc = cyc; ev_m.err = 1'b0; ev_m.data = data_a; obs_a.push_back(ev_m); end
      if (err_a)   begin ev_m.cyc = cyc; ev_m.err = 1'b1; ev_m.data = 8'h00;  obs_a.push_back(ev_m); end
      if (valid_b) begin ev_m.cyc = cyc; ev_m.err = 1'b0; ev_m.data = data_b; obs_b.push_back(ev_m); end
      if (err_b)   begin ev_m.cyc = cyc; ev_m.err = 1'b1; ev_m.data = 8'h00;  obs_b.push_back(ev_m); end
      if (valid_a && err_a) overlap_cnt++;
      if (valid_b && err_b) overlap_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame and log the pulse the receiver should produce.
  task automatic send_frame(input bit on_b, input logic [7:0] d, input logic stop_bit);
    int         cpb;
    ev_t        e;
    logic [9:0] bits;
    cpb    = on_b ? CPB_B : CPB_A;
    bits   = {stop_bit, d, 1'b0};
    e.cyc  = cyc + (cpb - 1) / 2 + 9 * cpb + 1 + LAT;
    e.err  = ~stop_bit;
    e.data = stop_bit ? d : 8'h00;
    if (on_b) exp_b.push_back(e); else exp_a.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (on_b) rx_b = bits[i]; else rx_a = bits[i];
      tick(cpb);
    end
  endtask

  task automatic compare_events(input string tag, input bit on_b);
    ev_t o[$];
    ev_t x[$];
    if (on_b) begin o = obs_b; x = exp_b; obs_b.delete(); exp_b.delete(); end
    else      begin o = obs_a; x = exp_a; obs_a.delete(); exp_a.delete(); end
    check({tag, "_count"}, o.size(), x.size());
    for (int i = 0; i < o.size() && i < x.size(); i++) begin
      check({tag, "_cyc"},  o[i].cyc,  x[i].cyc);
      check({tag, "_kind"}, o[i].err,  x[i].err);
      check({tag, "_data"}, o[i].data, x[i].data);
    end
  endtask

  initial begin
    logic [7:0]       d, last_a;
    int               gap;
    logic [LEN_A-1:0] v, e, got;

    reset = 1'b0; scan_enable = 1'b0; scan_in_a = 1'b0; scan_in_b = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; last_a = 8'h00;
    tick(3);

    // Reset state
    check("rst_data_a",  data_a,  8'h00);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_err_a",   err_a,   1'b0);
    check("rst_busy_a",  busy_a,  1'b0);
    check("rst_data_b",  data_b,  8'h00);
    check("rst_busy_b",  busy_b,  1'b0);
    reset = 1'b1; mon_en = 1'b1;
    tick(4);

    // Known byte, then random bytes with random idle gaps (0 = back-to-back)
    send_frame(1'b0, 8'hA5, 1'b1); last_a = 8'hA5;
    rx_a = 1'b1; tick(2);
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1'b0, d, 1'b1); last_a = d;
      rx_a = 1'b1;
      gap = $urandom_range(0, 3);
      tick(gap);
    end
    tick(15);
    compare_events("rand", 1'b0);
    check("rand_last_data", data_a, last_a);

    // Framing error, held-low break, recovery
    send_frame(1'b0, 8'h3C, 1'b0);
    rx_a = 1'b0; tick(20);
    compare_events("ferr", 1'b0);
    check("ferr_data_kept", data_a, last_a);
    check("ferr_busy_wait", busy_a, 1'b1);
    rx_a = 1'b1; tick(4);
    check("ferr_release_idle", busy_a, 1'b0);
    send_frame(1'b0, 8'h81, 1'b1);
    rx_a = 1'b1; tick(15);
    compare_events("recover", 1'b0);
    check("recover_data", data_a, 8'h81);

    // Back-to-back 0x00 then 0xFF
    send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b1);
    rx_a = 1'b1; tick(15);
    gap = (obs_a.size() >= 2) ? (obs_a[1].cyc - obs_a[0].cyc) : -1;
    check("b2b_gap", gap, 10);
    compare_events("b2b", 1'b0);

    // Slow receiver: short glitch rejected, then a full frame
    rx_b = 1'b0; tick(3);
    rx_b = 1'b1;
    check("glitch_busy", busy_b, 1'b1);
    tick(30);
    check("glitch_idle", busy_b, 1'b0);
    compare_events("glitch", 1'b1);
    send_frame(1'b1, 8'h5A, 1'b1);
    rx_b = 1'b1; tick(20);
    compare_events("slow", 1'b1);
    check("slow_data", data_b, 8'h5A);

    // Reset during data bit 4
    d = 8'($urandom_range(0, 255));
    rx_a = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin rx_a = d[i]; tick(); end
    check("midrst_busy_before", busy_a, 1'b1);
    rx_a = d[4]; reset = 1'b0; tick();
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_data", data_a, 8'h00);
    check("midrst_valid", valid_a, 1'b0);
    check("midrst_err", err_a, 1'b0);
    reset = 1'b1; rx_a = 1'b1; tick(20);
    check("midrst_idle", busy_a, 1'b0);
    compare_events("midrst", 1'b0);
    check("no_overlap", overlap_cnt, 0);

    // Scan chain: pattern 1011... delayed by the chain length
    mon_en = 1'b0;
    scan_enable = 1'b1;
    for (int k = 0; k < 2 * LEN_A; k++) begin
      scan_in_a = ((k % 4) != 1);
      if (k >= LEN_A) check("scan_shift", scan_out_a, (((k - LEN_A) % 4) != 1));
      tick();
    end

    // Scan-load DATA with bit_idx=7, one functional clock, then unload
    v = '0;
    v[LEN_A-1 -: 3]      = 3'b010;
    v[LEN_A-4-CW_A -: 3] = 3'b111;
    e = '0;
    e[LEN_A-1 -: 3]      = 3'b011;
    e[LEN_A-7-CW_A]      = 1'b1;
`ifdef UART_RX_SYNC_EN
    v[1:0] = 2'b11;
    e[1:0] = 2'b11;
`endif
    for (int k = 0; k < LEN_A; k++) begin
      scan_in_a = v[k];
      tick();
    end
    scan_enable = 1'b0; rx_a = 1'b1;
    tick();
    check("scan_func_busy", busy_a, 1'b1);
    scan_enable = 1'b1; scan_in_a = 1'b0;
    for (int k = 0; k < LEN_A; k++) begin
      got[k] = scan_out_a;
      tick();
    end
    check("scan_unload_state", got, e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
